// File: rtl/enum_sequencer_if.sv
// rtl/enum_sequencer_if.sv - command port bundle for the enumeration sequencer
interface enum_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int STEPW = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [STEPW-1:0] cmd_step;
    logic [WIDTH-1:0] cmd_value;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_step,
        output cmd_value,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_step,
        input  cmd_value,
        output cmd_ready
    );
endinterface

// File: rtl/enum_sequencer.sv
// rtl/enum_sequencer.sv - walks a sparse enumeration table with first/last/next/prev/load commands
module enum_sequencer #(
    parameter int                       WIDTH  = 32,
    parameter int                       COUNT  = 15,
    parameter logic [COUNT*WIDTH-1:0]   VALUES = {32'd32, 32'd31, 32'd30, 32'd22, 32'd21,
                                                  32'd20, 32'd12, 32'd11, 32'd10, 32'd5,
                                                  32'd4,  32'd3,  32'd2,  32'd1,  32'd0},
    parameter int                       STEPW  = 4,
    localparam int                      IDXW   = $clog2(COUNT)
) (
    input  logic              clk,
    input  logic              reset_l,
    enum_sequencer_if.slave   cmd,
    output logic [WIDTH-1:0]  cur_value,
    output logic [IDXW-1:0]   cur_index,
    output logic              cur_known,
    output logic [IDXW:0]     num,
    output logic              done,
    output logic              err,
    output logic              wrapped
);

    localparam logic [2:0] OP_FIRST = 3'd0;
    localparam logic [2:0] OP_LAST  = 3'd1;
    localparam logic [2:0] OP_NEXT  = 3'd2;
    localparam logic [2:0] OP_PREV  = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;

    localparam int            LAST_I   = COUNT - 1;
    localparam logic [IDXW:0] LAST_IDX = LAST_I[IDXW:0];
    localparam logic [IDXW:0] COUNT_W  = COUNT[IDXW:0];

    typedef enum logic [1:0] {IDLE, STEP, SEARCH} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic [IDXW-1:0]    index_q, index_d;
    logic               known_q, known_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               wrapped_q, wrapped_d;
    logic               ready_q, ready_d;
    logic [STEPW-1:0]   rem_q, rem_d;
    logic               fwd_q, fwd_d;
    logic               wflag_q, wflag_d;
    logic [IDXW:0]      widx_q, widx_d;
    logic [WIDTH-1:0]   key_q, key_d;

    logic               accept;
    logic [IDXW:0]      base_idx;
    logic               go_fwd;
    logic [IDXW:0]      step_idx;
    logic               step_wrap;
    logic [STEPW-1:0]   eff_step;
    logic [IDXW:0]      probe_idx;
    logic [WIDTH-1:0]   probe_key;

    function automatic logic [WIDTH-1:0] entry(input logic [IDXW:0] idx);
        entry = '0;
        for (int k = 0; k < COUNT; k++) begin
            if (idx == k[IDXW:0]) entry = VALUES[k*WIDTH +: WIDTH];
        end
    endfunction

    assign accept        = cmd.cmd_valid && ready_q;
    assign eff_step      = (cmd.cmd_step == '0) ? STEPW'(1) : cmd.cmd_step;
    assign cmd.cmd_ready = ready_q;
    assign cur_value     = value_q;
    assign cur_index     = index_q;
    assign cur_known     = known_q;
    assign num           = COUNT_W;
    assign done          = done_q;
    assign err           = err_q;
    assign wrapped       = wrapped_q;

    // The first step/compare happens in the acceptance cycle so a one-step
    // command completes with the same latency as FIRST/LAST.
    always_comb begin
        base_idx  = (state_q == IDLE) ? {1'b0, index_q} : widx_q;
        go_fwd    = (state_q == IDLE) ? (cmd.cmd_op == OP_NEXT) : fwd_q;
        probe_idx = (state_q == IDLE) ? '0 : widx_q;
        probe_key = (state_q == IDLE) ? cmd.cmd_value : key_q;
        step_wrap = 1'b0;
        if (go_fwd) begin
            if (base_idx == LAST_IDX) begin
                step_idx  = '0;
                step_wrap = 1'b1;
            end else begin
                step_idx = base_idx + 1'b1;
            end
        end else begin
            if (base_idx == '0) begin
                step_idx  = LAST_IDX;
                step_wrap = 1'b1;
            end else begin
                step_idx = base_idx - 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        index_d   = index_q;
        known_d   = known_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        wrapped_d = 1'b0;
        ready_d   = ready_q;
        rem_d     = rem_q;
        fwd_d     = fwd_q;
        wflag_d   = wflag_q;
        widx_d    = widx_q;
        key_d     = key_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_FIRST, OP_LAST: begin
                            index_d = (cmd.cmd_op == OP_FIRST) ? '0 : LAST_IDX[IDXW-1:0];
                            value_d = entry((cmd.cmd_op == OP_FIRST) ? '0 : LAST_IDX);
                            known_d = 1'b1;
                            done_d  = 1'b1;
                        end
                        OP_NEXT, OP_PREV: begin
                            if (!known_q) begin
                                done_d = 1'b1;
                                err_d  = 1'b1;
                            end else if (eff_step == STEPW'(1)) begin
                                index_d   = step_idx[IDXW-1:0];
                                value_d   = entry(step_idx);
                                done_d    = 1'b1;
                                wrapped_d = step_wrap;
                            end else begin
                                state_d = STEP;
                                ready_d = 1'b0;
                                rem_d   = eff_step - STEPW'(1);
                                fwd_d   = (cmd.cmd_op == OP_NEXT);
                                wflag_d = step_wrap;
                                widx_d  = step_idx;
                            end
                        end
                        OP_LOAD: begin
                            if (entry(probe_idx) == probe_key) begin
                                index_d = '0;
                                value_d = probe_key;
                                known_d = 1'b1;
                                done_d  = 1'b1;
                            end else begin
                                state_d = SEARCH;
                                ready_d = 1'b0;
                                key_d   = probe_key;
                                widx_d  = probe_idx + 1'b1;
                            end
                        end
                        default: begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end
            STEP: begin
                if (rem_q == STEPW'(1)) begin
                    index_d   = step_idx[IDXW-1:0];
                    value_d   = entry(step_idx);
                    done_d    = 1'b1;
                    wrapped_d = wflag_q | step_wrap;
                    ready_d   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    rem_d   = rem_q - STEPW'(1);
                    widx_d  = step_idx;
                    wflag_d = wflag_q | step_wrap;
                end
            end
            SEARCH: begin
                if (entry(probe_idx) == probe_key) begin
                    index_d = probe_idx[IDXW-1:0];
                    value_d = probe_key;
                    known_d = 1'b1;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else if (probe_idx == LAST_IDX) begin
                    // Not a member: keep the raw value but mark it unknown.
                    value_d = probe_key;
                    known_d = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    widx_d = probe_idx + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q   <= IDLE;
            value_q   <= '0;
            index_q   <= '0;
            known_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wrapped_q <= 1'b0;
            ready_q   <= 1'b1;
            rem_q     <= '0;
            fwd_q     <= 1'b0;
            wflag_q   <= 1'b0;
            widx_q    <= '0;
            key_q     <= '0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            index_q   <= index_d;
            known_q   <= known_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wrapped_q <= wrapped_d;
            ready_q   <= ready_d;
            rem_q     <= rem_d;
            fwd_q     <= fwd_d;
            wflag_q   <= wflag_d;
            widx_q    <= widx_d;
            key_q     <= key_d;
        end
    end

endmodule

// File: tb/tb_enum_sequencer.sv
// tb/tb_enum_sequencer.sv - directed self-checking bench for enum_sequencer
module tb_enum_sequencer;

    logic        clk;
    logic        reset_l;
    logic [31:0] cur_value;
    logic [3:0]  cur_index;
    logic        cur_known;
    logic [4:0]  num;
    logic        done;
    logic        err;
    logic        wrapped;

    int total;
    int bad;
    int lat;
    int done_seen;

    int exp_next_val [15] = '{1, 2, 3, 4, 5, 10, 11, 12, 20, 21, 22, 30, 31, 32, 0};

    enum_sequencer_if #(.WIDTH(32), .STEPW(4)) bus ();

    enum_sequencer dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .cmd       (bus),
        .cur_value (cur_value),
        .cur_index (cur_index),
        .cur_known (cur_known),
        .num       (num),
        .done      (done),
        .err       (err),
        .wrapped   (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Presents a command at the falling edge, releases it after acceptance and
    // returns the number of cycles until done (1 = visible right after acceptance).
    task automatic send(input logic [2:0] op, input logic [3:0] step, input logic [31:0] val,
                        output int cycles);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_step  = step;
        bus.cmd_value = val;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        cycles = 1;
        while (!done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!done) check("done_timeout", 64'(cycles), 64'(0));
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset_l       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_step  = 4'd0;
        bus.cmd_value = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_value", cur_value, 0);
        check("rst_index", cur_index, 0);
        check("rst_known", cur_known, 0);
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wrapped", wrapped, 0);
        check("num", num, 15);
        reset_l = 1'b1;

        send(3'd0, 4'd0, 32'd0, lat);
        check("first_lat", lat, 1);
        check("first_value", cur_value, 0);
        check("first_index", cur_index, 0);
        check("first_known", cur_known, 1);
        check("first_err", err, 0);

        for (int i = 0; i < 15; i++) begin
            send(3'd2, (i == 4) ? 4'd0 : 4'd1, 32'd0, lat);
            check("next_lat", lat, 1);
            check("next_value", cur_value, 64'(exp_next_val[i]));
            check("next_index", cur_index, 64'((i + 1) % 15));
            check("next_wrapped", wrapped, (i == 14) ? 64'd1 : 64'd0);
        end

        send(3'd1, 4'd0, 32'd0, lat);
        check("last_value", cur_value, 32);
        check("last_index", cur_index, 14);

        send(3'd3, 4'd3, 32'd0, lat);
        check("prev3_lat", lat, 3);
        check("prev3_value", cur_value, 22);
        check("prev3_index", cur_index, 11);
        check("prev3_wrapped", wrapped, 0);

        send(3'd3, 4'd12, 32'd0, lat);
        check("prev12_lat", lat, 12);
        check("prev12_value", cur_value, 32);
        check("prev12_index", cur_index, 14);
        check("prev12_wrapped", wrapped, 1);

        send(3'd4, 4'd0, 32'd20, lat);
        check("load20_lat", lat, 10);
        check("load20_index", cur_index, 9);
        check("load20_known", cur_known, 1);
        check("load20_value", cur_value, 20);
        check("load20_err", err, 0);

        send(3'd4, 4'd0, 32'd7, lat);
        check("load7_lat", lat, 15);
        check("load7_err", err, 1);
        check("load7_known", cur_known, 0);
        check("load7_value", cur_value, 7);
        check("load7_index", cur_index, 9);

        send(3'd2, 4'd1, 32'd0, lat);
        check("next_unknown_lat", lat, 1);
        check("next_unknown_err", err, 1);
        check("next_unknown_value", cur_value, 7);
        check("next_unknown_index", cur_index, 9);

        send(3'd6, 4'd0, 32'd0, lat);
        check("reserved_err", err, 1);
        check("reserved_value", cur_value, 7);

        // Valid held through a busy STEP, then re-used on the done cycle.
        send(3'd0, 4'd0, 32'd0, lat);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd2;
        bus.cmd_step  = 4'd3;
        @(posedge clk);
        #1;
        check("hold_ready_busy", bus.cmd_ready, 0);
        check("hold_done_early", done, 0);
        @(posedge clk);
        #1;
        check("hold_ready_busy2", bus.cmd_ready, 0);
        @(posedge clk);
        #1;
        check("hold_done", done, 1);
        check("hold_value", cur_value, 3);
        check("hold_index", cur_index, 3);
        check("hold_ready_back", bus.cmd_ready, 1);
        bus.cmd_op   = 3'd3;
        bus.cmd_step = 4'd1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("b2b_done", done, 1);
        check("b2b_value", cur_value, 2);
        check("b2b_index", cur_index, 2);
        @(posedge clk);
        #1;
        check("b2b_quiet", done, 0);

        // Reset in the middle of a LOAD search.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd4;
        bus.cmd_value = 32'd31;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midload_busy", bus.cmd_ready, 0);
        reset_l = 1'b0;
        #1;
        check("midrst_value", cur_value, 0);
        check("midrst_index", cur_index, 0);
        check("midrst_known", cur_known, 0);
        check("midrst_ready", bus.cmd_ready, 1);
        check("midrst_done", done, 0);
        repeat (2) @(negedge clk);
        reset_l   = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        check("midrst_ready_after", bus.cmd_ready, 1);
        check("midrst_known_after", cur_known, 0);

        send(3'd1, 4'd0, 32'd0, lat);
        check("post_rst_last_value", cur_value, 32);
        check("post_rst_last_known", cur_known, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enum_sequencer.md
Name: enum_sequencer

Overview:
- Synthesizable engine that holds a "current member" of a sparse, parametrised enumeration table.
- Supports first/last/next(N)/prev(N) stepping and value-to-index lookup, mirroring enum method semantics in hardware.
- Used as a reusable state-walker and as a regression target for sparse and wrapping enum encodings.
- Multi-cycle operations are serialised behind a valid/ready command port.

Parameters:
- WIDTH, 32: bit width of each enum value.
- COUNT, 15: number of members; must be ≥ 2.
- VALUES, {0,1,2,3,4,5,10,11,12,20,21,22,30,31,32}: packed COUNT*WIDTH table; member i occupies [i*WIDTH +: WIDTH].
- STEPW, 4: width of the step-count field.
- IDXW, $clog2(COUNT): derived localparam; index width.

Ports:
- clk, input, 1: rising-edge clock.
- reset_l, input, 1: asynchronous active-low reset.
- cmd_valid, input, 1: command request.
- cmd_ready, output, 1: engine idle; command accepted when cmd_valid && cmd_ready.
- cmd_op, input, 3: 0 FIRST, 1 LAST, 2 NEXT, 3 PREV, 4 LOAD; 5–7 reserved.
- cmd_step, input, STEPW: step count for NEXT/PREV; 0 is treated as 1.
- cmd_value, input, WIDTH: value for LOAD.
- cur_value, output, WIDTH: current value.
- cur_index, output, IDXW: table index of the current member.
- cur_known, output, 1: cur_value is a table member.
- num, output, IDXW+1: constant COUNT.
- done, output, 1: one-cycle pulse when a command completes.
- err, output, 1: one-cycle pulse, coincident with done, when a command fails.
- wrapped, output, 1: one-cycle pulse, coincident with done, if any step crossed the COUNT-1↔0 boundary.

Behaviour:
- Reset (async assert, sync deassert):
  - cur_value=0, cur_index=0, cur_known=0 (the "unset" state).
  - cmd_ready=1; done, err and wrapped all 0.
  - State goes to IDLE.
- State machine: IDLE, STEP, SEARCH. All outputs are registered.
- FIRST or LAST accepted in IDLE:
  - Next cycle: index becomes 0 or COUNT-1, value becomes the table entry, cur_known=1, done=1.
  - Stays in IDLE; cmd_ready remains 1.
- NEXT or PREV accepted with cur_known=0:
  - Next cycle: done=1, err=1, no state change.
- NEXT or PREV accepted with cur_known=1:
  - Go to STEP with remaining = max(cmd_step,1); cmd_ready=0.
  - Each STEP cycle moves the index by ±1 modulo COUNT and decrements remaining.
  - Wrap cases: NEXT at COUNT-1 → 0, and PREV at 0 → COUNT-1. Either case sets a sticky wrap flag.
  - On the cycle remaining reaches 0: cur_value and cur_index update, done=1, wrapped=flag, return to IDLE.
  - Latency: done asserts N cycles after acceptance (N = effective step).
  - cur_value and cur_index update only at completion; intermediate steps are not visible.
- LOAD:
  - Go to SEARCH; compare entry k at search cycle k, for k=0..COUNT-1.
  - First match wins (duplicate values permitted). On a match at k: cur_index=k, cur_value=entry, cur_known=1, done asserted k+1 cycles after acceptance.
  - No match: after COUNT cycles, cur_value=cmd_value (latched at acceptance), cur_known=0, cur_index unchanged, done=1, err=1.
- Reserved op: next cycle done=1, err=1, no state change.
- Handshake:
  - cmd_ready=0 throughout STEP and SEARCH.
  - cmd_ready returns to 1 in the same cycle done pulses, so a back-to-back command can be accepted on that cycle.
  - cmd_valid with cmd_ready=0 is ignored; no queueing.
  - Command fields are sampled only at acceptance.
- Reset mid-operation: returns immediately to reset values; the in-flight command is dropped and no done is issued.
- Width rules:
  - Index arithmetic uses IDXW+1 bits, with explicit compare against COUNT-1 (no reliance on power-of-2 wrap).
  - cmd_step is zero-extended.

Test Plan:
- Reset, then FIRST → 1 cycle later cur_value=0, cur_index=0, cur_known=1, done=1; num=15.
- From FIRST, NEXT step=1 repeated 15 times → values 1,2,3,4,5,10,11,12,20,21,22,30,31,32,0; wrapped=1 only on the 15th done; step=0 behaves as step=1.
- LAST, then PREV step=3 → done 3 cycles after acceptance, cur_value=22, cur_index=11, wrapped=0. Then PREV step=12 → cur_value=32, cur_index=14, wrapped=1.
- LOAD 20 → done exactly 10 cycles after acceptance, cur_index=9, cur_known=1. LOAD 7 → done after 15 cycles, err=1, cur_known=0, cur_value=7. Following NEXT → err=1, value unchanged.
- cmd_valid held during STEP/SEARCH → no extra acceptance; a back-to-back command accepted on the done cycle completes correctly.
- reset_l low during LOAD search at cycle 5 → all outputs at reset values immediately, no done pulse, cmd_ready=1 after deassert.
